// File: rtl/pll_drp_reconfig.sv
// DRP initiator for a PLLE2_ADV: runs a host-loaded table of read-modify-write
// operations with the PLL held in reset, then releases it and waits for lock.
module pll_drp_reconfig #(
    parameter int ENTRIES      = 8,
    parameter int RST_CYCLES   = 16,
    parameter int DRDY_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tbl_we,
    input  logic [$clog2(ENTRIES)-1:0] tbl_idx,
    input  logic [6:0]                 tbl_addr,
    input  logic [15:0]                tbl_mask,
    input  logic [15:0]                tbl_data,
    input  logic [$clog2(ENTRIES):0]   tbl_count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 error,
    output logic [6:0]                 drp_addr,
    output logic                       drp_den,
    output logic                       drp_dwe,
    output logic [15:0]                drp_di,
    input  logic [15:0]                drp_do,
    input  logic                       drp_drdy,
    output logic                       pll_rst,
    input  logic                       pll_locked
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int MAX_RD  = (RST_CYCLES > DRDY_TIMEOUT) ? RST_CYCLES : DRDY_TIMEOUT;
    localparam int CNT_MAX = (MAX_RD > LOCK_TIMEOUT) ? MAX_RD : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_PRE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RST_POST,
        S_LOCK_WAIT,
        S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DRDY = 2'd1,
        ERR_LOCK = 2'd2
    } err_t;

    logic [6:0]  tbl_addr_mem [ENTRIES];
    logic [15:0] tbl_mask_mem [ENTRIES];
    logic [15:0] tbl_data_mem [ENTRIES];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0]      data_q, data_d;
    logic [15:0]      wdata_q, wdata_d;
    err_t             err_q, err_d;
    logic             done_q, done_d;
    logic             lock_meta_q, lock_sync_q;
    logic [IDX_W:0]   next_idx;

    // NOTE: the table is plain storage with no reset so it maps onto distributed RAM;
    // software always reloads it before the first run.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_addr_mem[tbl_idx] <= tbl_addr;
            tbl_mask_mem[tbl_idx] <= tbl_mask;
            tbl_data_mem[tbl_idx] <= tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign next_idx = {1'b0, idx_q} + (IDX_W + 1)'(1);

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        count_d = count_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    err_d = ERR_NONE;
                    if (tbl_count == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        count_d = tbl_count;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RST_PRE;
                    end
                end
            end
            S_RST_PRE: begin
                if (cnt_q == RST_LAST) begin
                    // Entry fields are frozen here so table writes during the access are deferred.
                    addr_d  = tbl_addr_mem[idx_q];
                    mask_d  = tbl_mask_mem[idx_q];
                    data_d  = tbl_data_mem[idx_q];
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    wdata_d = (drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = ERR_DRDY;
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WR: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
                    cnt_d = '0;
                    if (next_idx < count_q) begin
                        idx_d   = next_idx[IDX_W-1:0];
                        addr_d  = tbl_addr_mem[next_idx[IDX_W-1:0]];
                        mask_d  = tbl_mask_mem[next_idx[IDX_W-1:0]];
                        data_d  = tbl_data_mem[next_idx[IDX_W-1:0]];
                        state_d = S_RD;
                    end else begin
                        state_d = S_RST_POST;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = ERR_DRDY;
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RST_POST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOCK_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOCK_WAIT: begin
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    err_d   = ERR_LOCK;
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_FAIL);
    assign done     = done_q;
    assign error    = err_q;
    assign drp_addr = addr_q;
    assign drp_den  = (state_q == S_RD) || (state_q == S_WR);
    assign drp_dwe  = (state_q == S_WR);
    assign drp_di   = wdata_q;
    // A DRDY failure keeps the PLL in reset so it never runs half-configured.
    assign pll_rst  = ((state_q != S_IDLE) && (state_q != S_LOCK_WAIT) && (state_q != S_FAIL))
                    || ((state_q == S_FAIL) && (err_q == ERR_DRDY));

endmodule
